// File: rtl/mem_arb.sv
// mem_arb: shares the single-port synchronous memory between fetch and data access.
// Data access wins by default; a starvation counter forces a fetch grant.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module mem_arb #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 8
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  iw_if_req,
    input  logic [`SIZE_ADDR-1:0] iw_if_addr,
    output logic                  ow_if_gnt,
    output logic                  ow_if_rvalid,
    output logic [`SIZE_DATA-1:0] ow_if_rdata,
    input  logic                  iw_ma_req,
    input  logic                  iw_ma_we,
    input  logic [`SIZE_ADDR-1:0] iw_ma_addr,
    input  logic [`SIZE_DATA-1:0] iw_ma_wdata,
    output logic                  ow_ma_gnt,
    output logic                  ow_ma_rvalid,
    output logic [`SIZE_DATA-1:0] ow_ma_rdata,
    output logic                  ow_mem_we,
    output logic [`SIZE_ADDR-1:0] ow_mem_addr,
    output logic [`SIZE_DATA-1:0] ow_mem_wdata,
    input  logic [`SIZE_DATA-1:0] iw_mem_rdata
);

    localparam logic [0:0] S_DPRI   = 1'b0;
    localparam logic [0:0] S_IFORCE = 1'b1;
    localparam logic [CNT_W:0] STARVE_LIM = (CNT_W+1)'(STARVE_MAX);

    logic [0:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W:0]   cnt_p1;
    logic             if_pend, ma_pend;

    assign cnt_p1 = {1'b0, cnt} + 1'b1;

    always_comb begin
        ow_if_gnt = 1'b0;
        ow_ma_gnt = 1'b0;
        state_nx  = state;
        cnt_nx    = cnt;
        if (iw_rst_n) begin
            case (state)
                S_DPRI: begin
                    if (iw_ma_req) begin
                        ow_ma_gnt = 1'b1;
                        if (iw_if_req) begin
                            // saturate rather than wrap so a huge count never releases IF late
                            cnt_nx = (&cnt) ? cnt : cnt_p1[CNT_W-1:0];
                            if (cnt_p1 == STARVE_LIM)
                                state_nx = S_IFORCE;
                        end else begin
                            cnt_nx = '0;
                        end
                    end else begin
                        ow_if_gnt = iw_if_req;
                        cnt_nx    = '0;
                    end
                end
                default: begin
                    ow_if_gnt = iw_if_req;
                    ow_ma_gnt = ~iw_if_req & iw_ma_req;
                    cnt_nx    = '0;
                    state_nx  = S_DPRI;
                end
            endcase
        end
    end

    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (ow_ma_gnt) begin
            ow_mem_we    = iw_ma_we;
            ow_mem_addr  = iw_ma_addr;
            ow_mem_wdata = iw_ma_wdata;
        end else if (ow_if_gnt) begin
            ow_mem_addr  = iw_if_addr;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            state   <= S_DPRI;
            cnt     <= '0;
            if_pend <= 1'b0;
            ma_pend <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            if_pend <= ow_if_gnt;
            ma_pend <= ow_ma_gnt & ~iw_ma_we;
        end
    end

    // a read granted just before reset must not surface while reset is held
    assign ow_if_rvalid = if_pend & iw_rst_n;
    assign ow_ma_rvalid = ma_pend & iw_rst_n;
    assign ow_if_rdata  = iw_mem_rdata;
    assign ow_ma_rdata  = iw_mem_rdata;

endmodule
